// File: rtl/if_stage.sv
// rtl/if_stage.sv - MIPS instruction-fetch stage: fetch PC, one-outstanding imem port, F/D register
// Redirects resolved in decode squash the wrong-path word (no delay slot).
module if_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        redirectD,
  input  logic [31:0] redirect_pcD,
  output logic        inst_req,
  output logic [31:0] inst_addr,
  input  logic        inst_addr_ok,
  input  logic        inst_data_ok,
  input  logic [31:0] inst_rdata,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcD,
  output logic [31:0] pcplus4D,
  output logic        validD
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic        discard_q, discard_d;
  logic [31:0] hold_q, hold_d;
  logic [31:0] pcF_q, pcF_d;
  logic [31:0] instrD_q, instrD_d;
  logic [31:0] pcD_q, pcD_d;
  logic [31:0] pcplus4D_q, pcplus4D_d;
  logic        validD_q, validD_d;

  logic        redir;
  logic        avail;
  logic        accept;
  logic [31:0] word;

  assign redir  = redirectD && !stallD;
  assign avail  = ((state_q == S_WAIT) && inst_data_ok && !discard_q) || (state_q == S_HOLD);
  assign word   = (state_q == S_HOLD) ? hold_q : inst_rdata;
  assign accept = avail && !stallF && !stallD && !redirectD;

  always_comb begin
    state_d   = state_q;
    discard_d = discard_q;
    hold_d    = hold_q;
    case (state_q)
      S_REQ: begin
        // A redirect landing on the accept cycle still owes the memory one response.
        if (inst_addr_ok) begin
          state_d   = S_WAIT;
          discard_d = redir;
        end
      end
      S_WAIT: begin
        if (inst_data_ok) begin
          discard_d = 1'b0;
          if (avail && !accept && !redir) begin
            state_d = S_HOLD;
            hold_d  = inst_rdata;
          end else begin
            state_d = S_REQ;
          end
        end else if (redir) begin
          discard_d = 1'b1;
        end
      end
      S_HOLD: begin
        if (accept || redir) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  always_comb begin
    pcF_d      = pcF_q;
    instrD_d   = 32'h0;
    validD_d   = 1'b0;
    pcD_d      = pcD_q;
    pcplus4D_d = pcplus4D_q;
    if (redir) begin
      pcF_d = redirect_pcD;
    end else if (accept) begin
      pcF_d = pcF_q + 32'd4;
    end
    if (!redir && stallD) begin
      instrD_d = instrD_q;
      validD_d = validD_q;
    end else if (!redir && accept) begin
      instrD_d   = word;
      validD_d   = 1'b1;
      pcD_d      = pcF_q;
      pcplus4D_d = pcF_q + 32'd4;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_REQ;
      discard_q  <= 1'b0;
      hold_q     <= 32'h0;
      pcF_q      <= RESET_PC;
      instrD_q   <= 32'h0;
      pcD_q      <= 32'h0;
      pcplus4D_q <= 32'h0;
      validD_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      discard_q  <= discard_d;
      hold_q     <= hold_d;
      pcF_q      <= pcF_d;
      instrD_q   <= instrD_d;
      pcD_q      <= pcD_d;
      pcplus4D_q <= pcplus4D_d;
      validD_q   <= validD_d;
    end
  end

  assign inst_req  = (state_q == S_REQ) && !rst;
  assign inst_addr = pcF_q;
  assign pcF       = pcF_q;
  assign instrD    = instrD_q;
  assign pcD       = pcD_q;
  assign pcplus4D  = pcplus4D_q;
  assign validD    = validD_q;

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - directed bench for if_stage with memory responder and transaction-level model
module tb_if_stage;

  localparam logic [31:0] K = 32'hABCD_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallF, stallD, redirectD;
  logic [31:0] redirect_pcD;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_addr_ok;
  logic        inst_data_ok;
  logic [31:0] inst_rdata;
  logic [31:0] pcF, instrD, pcD, pcplus4D;
  logic        validD;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .stallF(stallF), .stallD(stallD),
    .redirectD(redirectD), .redirect_pcD(redirect_pcD),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
    .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .pcF(pcF), .instrD(instrD), .pcD(pcD), .pcplus4D(pcplus4D), .validD(validD)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Memory: one outstanding request, data after mem_lat extra cycles, rdata = addr ^ K.
  logic        mem_pend;
  logic [31:0] mem_addr;
  int          mem_dly, mem_lat, gate;
  logic [31:0] req_log[$];
  logic        s_req, s_aok, s_dok;
  logic [31:0] s_addr;

  assign inst_addr_ok = inst_req && !mem_pend && (gate == 0);

  initial begin
    mem_pend = 1'b0; mem_addr = 32'h0; mem_dly = 0; mem_lat = 0; gate = 0;
    inst_data_ok = 1'b0; inst_rdata = 32'hFFFF_FFFF;
    forever begin
      @(negedge clk);
      s_req = inst_req; s_aok = inst_addr_ok; s_addr = inst_addr; s_dok = inst_data_ok;
      @(posedge clk);
      #1;
      if (s_dok) mem_pend = 1'b0;
      if (s_req && s_aok) begin
        mem_pend = 1'b1; mem_addr = s_addr; mem_dly = mem_lat;
        req_log.push_back(s_addr);
      end
      if (gate > 0) gate--;
      inst_data_ok = 1'b0;
      inst_rdata   = 32'hFFFF_FFFF;
      if (mem_pend) begin
        if (mem_dly == 0) begin
          inst_data_ok = 1'b1;
          inst_rdata   = mem_addr ^ K;
        end else begin
          mem_dly--;
        end
      end
    end
  end

  // Model: tracks the in-flight fetch as a transaction that is live or already stale.
  logic [31:0] m_pc_q, m_instr_q, m_pcd_q, m_pcp4_q, m_buf_q;
  logic        m_out_q, m_live_q, m_bufv_q, m_v_q;
  logic [31:0] m_pc_d, m_instr_d, m_pcd_d, m_pcp4_d, m_buf_d, m_word;
  logic        m_out_d, m_live_d, m_bufv_d, m_v_d;
  logic        m_req, m_fresh, m_have, m_take, m_redir;

  always_comb begin
    m_req   = !m_out_q && !m_bufv_q;
    m_fresh = m_out_q && inst_data_ok && m_live_q;
    m_have  = m_fresh || m_bufv_q;
    m_word  = m_bufv_q ? m_buf_q : inst_rdata;
    m_take  = m_have && !stallF && !stallD && !redirectD;
    m_redir = redirectD && !stallD;
    m_pc_d  = m_redir ? redirect_pcD : (m_take ? m_pc_q + 32'd4 : m_pc_q);
    m_instr_d = 32'h0; m_v_d = 1'b0; m_pcd_d = m_pcd_q; m_pcp4_d = m_pcp4_q;
    if (m_redir) begin
      m_instr_d = 32'h0;
    end else if (stallD) begin
      m_instr_d = m_instr_q; m_v_d = m_v_q;
    end else if (m_take) begin
      m_instr_d = m_word; m_v_d = 1'b1; m_pcd_d = m_pc_q; m_pcp4_d = m_pc_q + 32'd4;
    end
    m_out_d = m_out_q; m_live_d = m_live_q; m_bufv_d = m_bufv_q; m_buf_d = m_buf_q;
    if (m_req && inst_addr_ok) begin
      m_out_d = 1'b1; m_live_d = !m_redir;
    end
    if (m_out_q && inst_data_ok) begin
      m_out_d = 1'b0;
      if (m_fresh && !m_take && !m_redir) begin
        m_bufv_d = 1'b1; m_buf_d = inst_rdata;
      end
    end else if (m_out_q && m_redir) begin
      m_live_d = 1'b0;
    end
    if (m_bufv_q && (m_take || m_redir)) m_bufv_d = 1'b0;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_pc_q <= 32'h0; m_instr_q <= 32'h0; m_pcd_q <= 32'h0; m_pcp4_q <= 32'h0;
      m_v_q <= 1'b0; m_out_q <= 1'b0; m_live_q <= 1'b0; m_bufv_q <= 1'b0; m_buf_q <= 32'h0;
    end else begin
      m_pc_q <= m_pc_d; m_instr_q <= m_instr_d; m_pcd_q <= m_pcd_d; m_pcp4_q <= m_pcp4_d;
      m_v_q <= m_v_d; m_out_q <= m_out_d; m_live_q <= m_live_d; m_bufv_q <= m_bufv_d;
      m_buf_q <= m_buf_d;
    end
  end

  logic [31:0] d_log[$];
  logic        prev_v = 1'b0;
  logic [31:0] prev_pcd = 32'h0;

  always @(negedge clk) begin
    chk("cyc.inst_req", 32'(inst_req), 32'(m_req && !rst));
    chk("cyc.inst_addr", inst_addr, m_pc_q);
    chk("cyc.pcF", pcF, m_pc_q);
    chk("cyc.instrD", instrD, m_instr_q);
    chk("cyc.pcD", pcD, m_pcd_q);
    chk("cyc.pcplus4D", pcplus4D, m_pcp4_q);
    chk("cyc.validD", 32'(validD), 32'(m_v_q));
    if (validD && (!prev_v || pcD != prev_pcd)) d_log.push_back(pcD);
    prev_v = validD;
    prev_pcd = pcD;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic bit cond(input int sel);
    case (sel)
      0: return inst_data_ok && mem_addr == 32'h8;
      1: return mem_pend && mem_addr == 32'h10 && !inst_data_ok;
      2: return validD && pcD == 32'h100;
      3: return inst_data_ok && mem_addr == 32'h104;
      4: return validD && pcD == 32'h300;
      5: return validD && pcD == 32'h4;
      default: return 1'b0;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string name);
    for (int i = 0; i < 60 && !cond(sel); i++) step();
    chk(name, 32'(cond(sel)), 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    automatic logic [31:0] exp_d[8]   = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h100, 32'h300, 32'h0, 32'h4};
    automatic logic [31:0] exp_r[11]  = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10, 32'h100,
                                          32'h104, 32'h300, 32'h304, 32'h0, 32'h4};
    rst = 1'b1; stallF = 1'b0; stallD = 1'b0; redirectD = 1'b0; redirect_pcD = 32'h0;
    repeat (2) @(posedge clk);
    #2;
    chk("rst.pcF", pcF, 32'h0);
    chk("rst.inst_req", 32'(inst_req), 32'd0);
    chk("rst.validD", 32'(validD), 32'd0);
    chk("rst.instrD", instrD, 32'h0);
    chk("rst.pcD", pcD, 32'h0);
    chk("rst.pcplus4D", pcplus4D, 32'h0);
    rst = 1'b0;
    #1;
    chk("first.inst_req", 32'(inst_req), 32'd1);
    chk("first.inst_addr", inst_addr, 32'h0);

    // Stall both stages for three cycles while the word for pc=8 returns.
    wait_for(0, "wait.data8");
    stallF = 1'b1; stallD = 1'b1;
    step(); step();
    chk("stall.inst_req", 32'(inst_req), 32'd0);
    chk("stall.validD", 32'(validD), 32'd0);
    chk("stall.pcD", pcD, 32'h4);
    chk("stall.pcF", pcF, 32'h8);
    step();
    stallF = 1'b0; stallD = 1'b0;
    step();
    chk("release.pcD", pcD, 32'h8);
    chk("release.instrD", instrD, 32'h8 ^ K);
    chk("release.validD", 32'(validD), 32'd1);
    chk("release.pcplus4D", pcplus4D, 32'hC);
    chk("release.pcF", pcF, 32'hC);

    // Redirect while 0x10 is outstanding.
    mem_lat = 2;
    wait_for(1, "wait.wait10");
    redirectD = 1'b1; redirect_pcD = 32'h100; mem_lat = 0;
    step();
    redirectD = 1'b0;
    chk("redir_wait.pcF", pcF, 32'h100);
    chk("redir_wait.validD", 32'(validD), 32'd0);
    chk("redir_wait.pcD", pcD, 32'hC);
    chk("redir_wait.inst_req", 32'(inst_req), 32'd0);
    wait_for(2, "wait.load100");

    // Redirect on the data cycle of 0x104, then hold addr_ok low for four cycles.
    wait_for(3, "wait.data104");
    redirectD = 1'b1; redirect_pcD = 32'h200; gate = 5;
    step();
    redirectD = 1'b0;
    chk("redir_data.validD", 32'(validD), 32'd0);
    chk("redir_data.pcF", pcF, 32'h200);
    chk("redir_data.inst_req", 32'(inst_req), 32'd1);
    chk("redir_data.inst_addr", inst_addr, 32'h200);
    step();
    chk("gate.inst_req", 32'(inst_req), 32'd1);
    chk("gate.inst_addr", inst_addr, 32'h200);
    step();
    redirectD = 1'b1; redirect_pcD = 32'h300;
    step();
    redirectD = 1'b0;
    chk("gate_redir.inst_req", 32'(inst_req), 32'd1);
    chk("gate_redir.inst_addr", inst_addr, 32'h300);
    chk("gate_redir.validD", 32'(validD), 32'd0);
    wait_for(4, "wait.load300");

    // Reset while 0x304 is outstanding; its late response must be ignored.
    mem_lat = 3;
    step();
    rst = 1'b1;
    #1;
    chk("midrst.pcF", pcF, 32'h0);
    chk("midrst.validD", 32'(validD), 32'd0);
    chk("midrst.inst_req", 32'(inst_req), 32'd0);
    chk("midrst.instrD", instrD, 32'h0);
    step();
    rst = 1'b0; mem_lat = 0;
    wait_for(5, "wait.load4");
    step(); step();

    chk("dlog.size_ok", 32'(d_log.size() >= 8), 32'd1);
    for (int i = 0; i < 8; i++)
      if (i < d_log.size()) chk($sformatf("dlog[%0d]", i), d_log[i], exp_d[i]);
    chk("reqlog.size_ok", 32'(req_log.size() >= 11), 32'd1);
    for (int i = 0; i < 11; i++)
      if (i < req_log.size()) chk($sformatf("reqlog[%0d]", i), req_log[i], exp_r[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
